// File: rtl/bitty_ctrl.sv
// bitty_ctrl: multi-cycle control unit for the bitty 16-bit datapath; legal instructions retire 5 cycles after run.
// Define BITTY_CTRL_IMM_EN to decode format 01 as Rx <- Rx op imm8; otherwise format 01 is illegal.
module bitty_ctrl (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        run_i,
  input  logic [15:0] instruction_i,
  output logic [15:0] alu_a_o,
  output logic [15:0] alu_b_o,
  output logic [2:0]  alu_sel_o,
  input  logic [15:0] alu_out_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        err_o,
  input  logic        dbg_we_i,
  input  logic [2:0]  dbg_addr_i,
  input  logic [15:0] dbg_wdata_i,
  output logic [15:0] dbg_rdata_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH_A,
    S_FETCH_B,
    S_EXEC,
    S_WB
  } state_t;

  state_t      state_q;
  logic [15:0] rf_q [8];
  logic [2:0]  rx_q;
  logic [2:0]  ry_q;
  logic [2:0]  sel_q;
  logic [15:0] alu_a_q;
  logic [15:0] alu_b_q;
  logic [2:0]  alu_sel_q;
  logic [15:0] res_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;
  logic        legal_d;

`ifdef BITTY_CTRL_IMM_EN
  logic        imm_fmt_q;
  logic [7:0]  imm_q;
`else
  logic        unused_imm_bits;
  assign unused_imm_bits = ^instruction_i[9:5];
`endif

  always_comb begin
    legal_d = 1'b0;
    case (instruction_i[1:0])
      2'b00:   legal_d = 1'b1;
`ifdef BITTY_CTRL_IMM_EN
      2'b01:   legal_d = 1'b1;
`endif
      default: legal_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= S_IDLE;
      rx_q      <= '0;
      ry_q      <= '0;
      sel_q     <= '0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_sel_q <= '0;
      res_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef BITTY_CTRL_IMM_EN
      imm_fmt_q <= 1'b0;
      imm_q     <= '0;
`endif
      for (int i = 0; i < 8; i++) rf_q[i] <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          // Debug write and instruction latch may share this edge; operands are read later.
          if (dbg_we_i) rf_q[dbg_addr_i] <= dbg_wdata_i;
          if (run_i) begin
            rx_q  <= instruction_i[15:13];
            ry_q  <= instruction_i[12:10];
            sel_q <= instruction_i[4:2];
`ifdef BITTY_CTRL_IMM_EN
            imm_fmt_q <= instruction_i[0];
            imm_q     <= instruction_i[12:5];
`endif
            if (legal_d) begin
              state_q <= S_FETCH_A;
              busy_q  <= 1'b1;
            end else begin
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end
          end
        end
        S_FETCH_A: begin
          alu_a_q   <= rf_q[rx_q];
          alu_sel_q <= sel_q;
          state_q   <= S_FETCH_B;
        end
        S_FETCH_B: begin
`ifdef BITTY_CTRL_IMM_EN
          alu_b_q <= imm_fmt_q ? {8'h00, imm_q} : rf_q[ry_q];
`else
          alu_b_q <= rf_q[ry_q];
`endif
          state_q <= S_EXEC;
        end
        S_EXEC: begin
          res_q   <= alu_out_i;
          state_q <= S_WB;
        end
        S_WB: begin
          rf_q[rx_q] <= res_q;
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign alu_a_o     = alu_a_q;
  assign alu_b_o     = alu_b_q;
  assign alu_sel_o   = alu_sel_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign dbg_rdata_o = rf_q[dbg_addr_i];

endmodule

// File: tb/tb_bitty_ctrl.sv
// Self-checking bench for bitty_ctrl: vector table plus hand sequences, with a behavioural ALU attached.
module tb_bitty_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        run = 1'b0;
  logic [15:0] instruction = '0;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_sel;
  logic        busy, done, err;
  logic        dbg_we = 1'b0;
  logic [2:0]  dbg_addr = '0;
  logic [15:0] dbg_wdata = '0;
  logic [15:0] dbg_rdata;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bitty_ctrl dut (
    .clk_i(clk), .reset_i(reset), .run_i(run), .instruction_i(instruction),
    .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_sel_o(alu_sel), .alu_out_i(alu_out),
    .busy_o(busy), .done_o(done), .err_o(err),
    .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata), .dbg_rdata_o(dbg_rdata)
  );

  // External ALU: 111 is compare (0 equal, 1 a>b, 2 a<b).
  always_comb begin
    case (alu_sel)
      3'b000:  alu_out = alu_a + alu_b;
      3'b001:  alu_out = alu_a - alu_b;
      3'b010:  alu_out = alu_a & alu_b;
      3'b011:  alu_out = alu_a | alu_b;
      3'b100:  alu_out = alu_a ^ alu_b;
      3'b101:  alu_out = alu_a << alu_b[3:0];
      3'b110:  alu_out = alu_a >> alu_b[3:0];
      default: alu_out = (alu_a == alu_b) ? 16'd0 : ((alu_a > alu_b) ? 16'd1 : 16'd2);
    endcase
  end

  typedef struct {
    logic [2:0]  rx;
    logic [2:0]  ry;
    logic [2:0]  sel;
    logic [1:0]  fmt;
    logic [7:0]  imm;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [2:0]  rx;
    logic [15:0] val;
    logic        err;
    int          lat;
    int          cyc;
  } sb_t;

  vec_t vecs[14];
  sb_t  sb[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] enc(input vec_t v);
    if (v.fmt == 2'b01) return {v.rx, v.imm, v.sel, v.fmt};
    return {v.rx, v.ry, 5'b00000, v.sel, v.fmt};
  endfunction

  function automatic logic [15:0] reg_op(input logic [2:0] rx, input logic [2:0] ry, input logic [2:0] sel);
    return {rx, ry, 5'b00000, sel, 2'b00};
  endfunction

  task automatic dbg_write(input logic [2:0] a, input logic [15:0] d);
    dbg_we = 1'b1; dbg_addr = a; dbg_wdata = d;
    @(negedge clk);
    dbg_we = 1'b0;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [15:0] d);
    dbg_addr = a;
    #1;
    d = dbg_rdata;
  endtask

  // Called at a negedge; returns at the negedge of the cycle after run is sampled.
  task automatic issue(input logic [15:0] inst, input logic [2:0] rx, input logic [15:0] val,
                       input logic e);
    sb_t s;
    s.rx = rx; s.val = val; s.err = e; s.lat = e ? 1 : 5; s.cyc = cyc;
    sb.push_back(s);
    run = 1'b1; instruction = inst;
    @(negedge clk);
    run = 1'b0;
  endtask

  task automatic wait_done(input string name);
    sb_t s;
    int n = 0;
    int busy_cnt = 0;
    logic [15:0] rd;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++; failures++;
      $display("FAIL %s_timeout: got no done expected done within 20 cycles", name);
      if (sb.size() != 0) void'(sb.pop_front());
      return;
    end
    if (sb.size() == 0) begin
      checks++; failures++;
      $display("FAIL %s_unexpected_done: got done expected none", name);
      return;
    end
    s = sb.pop_front();
    chk({name, "_latency"}, 16'(cyc - s.cyc), 16'(s.lat));
    chk({name, "_err"}, {15'd0, err}, {15'd0, s.err});
    chk({name, "_busy_cycles"}, 16'(busy_cnt), 16'(n));
    chk({name, "_busy_at_done"}, {15'd0, busy}, 16'd0);
    read_reg(s.rx, rd);
    chk({name, "_rx"}, rd, s.val);
  endtask

  initial begin
    logic [15:0] rd;
    int done_cnt;
    int busy_cnt;
    vec_t v;

    vecs[0]  = '{3'd1, 3'd2, 3'b000, 2'b00, 8'h00, 16'h0005, 16'h0003, 16'h0008, 1'b0};
    vecs[1]  = '{3'd3, 3'd4, 3'b111, 2'b00, 8'h00, 16'h0002, 16'h0007, 16'h0002, 1'b0};
    vecs[2]  = '{3'd3, 3'd4, 3'b111, 2'b00, 8'h00, 16'h0007, 16'h0007, 16'h0000, 1'b0};
    vecs[3]  = '{3'd5, 3'd6, 3'b111, 2'b00, 8'h00, 16'h0009, 16'h0003, 16'h0001, 1'b0};
    vecs[4]  = '{3'd2, 3'd7, 3'b001, 2'b00, 8'h00, 16'h0003, 16'h0005, 16'hFFFE, 1'b0};
    vecs[5]  = '{3'd0, 3'd1, 3'b000, 2'b00, 8'h00, 16'hFFFF, 16'h0002, 16'h0001, 1'b0};
    vecs[6]  = '{3'd6, 3'd6, 3'b100, 2'b00, 8'h00, 16'h1234, 16'h1234, 16'h0000, 1'b0};
    vecs[7]  = '{3'd4, 3'd5, 3'b010, 2'b00, 8'h00, 16'hF0F0, 16'h0FF0, 16'h00F0, 1'b0};
    vecs[8]  = '{3'd7, 3'd0, 3'b011, 2'b00, 8'h00, 16'h1200, 16'h0034, 16'h1234, 1'b0};
    vecs[9]  = '{3'd1, 3'd3, 3'b101, 2'b00, 8'h00, 16'h0003, 16'h0004, 16'h0030, 1'b0};
    vecs[10] = '{3'd2, 3'd5, 3'b110, 2'b00, 8'h00, 16'h8000, 16'h000F, 16'h0001, 1'b0};
`ifdef BITTY_CTRL_IMM_EN
    vecs[11] = '{3'd0, 3'd0, 3'b000, 2'b01, 8'hA5, 16'h0000, 16'h0000, 16'h00A5, 1'b0};
`else
    vecs[11] = '{3'd0, 3'd0, 3'b000, 2'b01, 8'hA5, 16'h0000, 16'h0000, 16'h0000, 1'b1};
`endif
    vecs[12] = '{3'd2, 3'd3, 3'b000, 2'b11, 8'h00, 16'h0042, 16'h0001, 16'h0042, 1'b1};
    vecs[13] = '{3'd4, 3'd1, 3'b001, 2'b10, 8'h00, 16'h0077, 16'h0011, 16'h0077, 1'b1};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("reset_busy", {15'd0, busy}, 16'd0);
    chk("reset_done", {15'd0, done}, 16'd0);
    chk("reset_err", {15'd0, err}, 16'd0);
    chk("reset_alu_a", alu_a, 16'd0);
    chk("reset_alu_b", alu_b, 16'd0);
    chk("reset_alu_sel", {13'd0, alu_sel}, 16'd0);
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), rd);
      chk("reset_rf", rd, 16'd0);
    end
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      v = vecs[i];
      dbg_write(v.rx, v.a);
      if (v.fmt != 2'b01 && v.rx != v.ry) dbg_write(v.ry, v.b);
      issue(enc(v), v.rx, v.exp, v.exp_err);
      wait_done("vec");
      if (v.fmt != 2'b01 && v.rx != v.ry) begin
        read_reg(v.ry, rd);
        chk("vec_ry_unchanged", rd, v.b);
      end
      @(negedge clk);
      chk("vec_done_one_cycle", {15'd0, done}, 16'd0);
      chk("vec_err_one_cycle", {15'd0, err}, 16'd0);
    end

    // run and dbg_we while busy are both ignored.
    dbg_write(3'd1, 16'h0010);
    dbg_write(3'd2, 16'h0020);
    dbg_write(3'd3, 16'h0030);
    dbg_write(3'd4, 16'h0044);
    issue(reg_op(3'd1, 3'd2, 3'b000), 3'd1, 16'h0030, 1'b0);
    run = 1'b1; instruction = reg_op(3'd3, 3'd2, 3'b000);
    dbg_we = 1'b1; dbg_addr = 3'd4; dbg_wdata = 16'hDEAD;
    @(negedge clk);
    run = 1'b0; dbg_we = 1'b0;
    wait_done("busy_ignore");
    done_cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    chk("busy_run_no_extra_done", 16'(done_cnt), 16'd0);
    read_reg(3'd3, rd);
    chk("busy_run_r3_unchanged", rd, 16'h0030);
    read_reg(3'd4, rd);
    chk("busy_dbg_we_ignored", rd, 16'h0044);

    // Debug write and run in the same IDLE cycle: the instruction sees the new value.
    dbg_write(3'd6, 16'h0001);
    dbg_we = 1'b1; dbg_addr = 3'd5; dbg_wdata = 16'h0010;
    issue(reg_op(3'd5, 3'd6, 3'b000), 3'd5, 16'h0011, 1'b0);
    dbg_we = 1'b0;
    wait_done("dbg_with_run");
    @(negedge clk);

    // Back-to-back: second run asserted in the done cycle.
    dbg_write(3'd1, 16'h0001);
    dbg_write(3'd2, 16'h0002);
    issue(reg_op(3'd1, 3'd2, 3'b000), 3'd1, 16'h0003, 1'b0);
    wait_done("b2b_first");
    issue(reg_op(3'd1, 3'd2, 3'b000), 3'd1, 16'h0005, 1'b0);
    wait_done("b2b_second");
    @(negedge clk);

    // Reset during EXEC: no writeback, no done, register file cleared.
    dbg_write(3'd2, 16'h0009);
    dbg_write(3'd3, 16'h0004);
    run = 1'b1; instruction = reg_op(3'd2, 3'd3, 3'b001);
    @(negedge clk);
    instruction = reg_op(3'd5, 3'd6, 3'b000);
    @(negedge clk);
    run = 1'b0;
    @(negedge clk);
    chk("pre_reset_busy", {15'd0, busy}, 16'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    done_cnt = 0;
    busy_cnt = 0;
    repeat (8) begin
      if (done) done_cnt++;
      if (busy) busy_cnt++;
      @(negedge clk);
    end
    chk("midreset_no_done", 16'(done_cnt), 16'd0);
    chk("midreset_no_busy", 16'(busy_cnt), 16'd0);
    for (int i = 0; i < 8; i++) begin
      read_reg(3'(i), rd);
      chk("midreset_rf_cleared", rd, 16'd0);
    end
    chk("midreset_sb_empty", 16'(sb.size()), 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bitty_ctrl.md
# bitty_ctrl

Multi-cycle control unit for the bitty 16-bit datapath. It accepts one instruction word per `run` request and decodes it. It reads operands from an internal 8×16 register file, drives the external combinational ALU (`alu_a`, `alu_b`, `alu_sel`), captures the ALU result and writes it back to the destination register. It is the ALU's issuing/consuming side: the ALU only computes, and this block sequences everything around it.

## Interface
Parameters:
- none (widths fixed: 16-bit data, 8 registers, 3-bit ALU select)

Ports:
- `clk`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  synchronous, active-high; clears FSM, latches, register file
- `run`  in  1  start request; sampled only in IDLE
- `instruction`  in  16  instruction word, sampled with `run`
- `alu_a`  out  16  ALU operand A (registered)
- `alu_b`  out  16  ALU operand B (registered)
- `alu_sel`  out  3  ALU operation select (registered)
- `alu_out`  in  16  ALU result, combinational from `alu_a`/`alu_b`/`alu_sel`
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse: instruction retired
- `err`  out  1  one-cycle pulse together with `done` for an illegal instruction
- `dbg_we`  in  1  debug register write; honoured only in IDLE
- `dbg_addr`  in  3  debug register address (read and write)
- `dbg_wdata`  in  16  debug write data
- `dbg_rdata`  out  16  combinational read of `rf[dbg_addr]`

## Operation
- Instruction fields:
  - `[15:13]` Rx (source A and destination)
  - `[12:10]` Ry
  - `[4:2]` ALU sel
  - `[1:0]` format
- Formats:
  - `00`: register. Rx ← Rx op Ry.
  - `01`: immediate. Rx ← Rx op {8'h00, inst[12:5]}; only with the macro enabled.
  - `10`/`11`: illegal.
- FSM states: IDLE → FETCH_A → FETCH_B → EXEC → WB → IDLE.
  - IDLE: on `run`, latch the instruction. Legal → FETCH_A. Illegal → stay IDLE and pulse `done` and `err` next cycle; no register is modified.
  - FETCH_A: `alu_a` ← rf[Rx]; `alu_sel` ← inst[4:2].
  - FETCH_B: `alu_b` ← rf[Ry] (format 00) or zero-extended imm8 (format 01).
  - EXEC: result latch ← `alu_out`.
  - WB: rf[Rx] ← result latch; `done` ← 1; → IDLE.
- `run` outside IDLE is ignored; there is no queueing.
- `dbg_we` outside IDLE is ignored. When `dbg_we` and `run` arrive in the same IDLE cycle, both act: the debug write lands at the same edge the instruction is latched. Operands are read later, so an instruction sees the debug-written value.
- All arithmetic is 16-bit modulo. Results are written exactly as the ALU returns them, including compare codes 0/1/2.
- Rx == Ry is legal; both operands read the same register.

## Timing
- Reset values:
  - state IDLE
  - `alu_a`, `alu_b` = 16'h0000; `alu_sel` = 3'b000
  - `busy` = 0, `done` = 0, `err` = 0
  - all registers 16'h0000
- Latency for a legal instruction:
  - `run` is sampled at edge E0.
  - `done` is high in the cycle after edge E4 (5 cycles after the `run` cycle).
  - The written register is visible on `dbg_rdata` in that same cycle.
- Illegal instruction: `done` and `err` are high in the cycle after E0.
- Back-to-back: `run` may be asserted in the cycle where `done` = 1, giving 1 instruction per 5 cycles sustained.
- `busy` is high from the cycle after E0 through the WB cycle.
- `alu_out` is consumed only at the EXEC edge; ALU combinational delay must fit one cycle.
- Reset mid-operation (any state): next cycle is IDLE. There is no writeback and no `done` pulse, and the register file is cleared.

## Configuration
- `BITTY_CTRL_IMM_EN` defined: format `01` is decoded as an immediate instruction.
- Undefined: format `01` is illegal, giving `done` + `err` and no write. No immediate mux is synthesized.

## Test plan
- Reset, then check: `dbg_rdata` = 0 for all 8 addresses; `busy`/`done`/`err` = 0; `alu_*` = 0.
- Set R1 = 5 and R2 = 3 via debug writes. Issue register ADD R1,R2 (sel 000) → `done` exactly 5 cycles after `run`; R1 = 16'h0008; R2 unchanged.
- Set R3 = 2 and R4 = 7. Issue compare R3,R4 (sel 111) → R3 = 16'h0002. Then set R3 = 7 and compare again → R3 = 16'h0000.
- With `BITTY_CTRL_IMM_EN`: R0 = 0, immediate ADD R0, imm 8'hA5 → R0 = 16'h00A5. Without the macro: same word → `err` = 1 one cycle after `run`, R0 unchanged.
- Issue SUB, pulse `run` again while `busy`, then assert `reset` during EXEC → second `run` ignored; after reset all registers are 0 and no `done` pulse appears.
- Illegal format `11` → `done` = `err` = 1 for exactly one cycle; `busy` never asserts.
